// File: rtl/nib_rr_sched.sv
// Round-robin scheduler feeding one shared nibble datapath stage through valid/ready.
// Optional transfer abort on a stalled datapath: define NIB_RR_SCHED_TIMEOUT_EN.
module nib_rr_sched #(
   parameter int NREQ    = 4,
   parameter int W       = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*W-1:0]   data_in,
   output logic [NREQ-1:0]     grant,
   output logic                dp_valid,
   input  logic                dp_ready,
   output logic [W-1:0]        dp_data,
   output logic [2:0]          dp_src,
   output logic                busy,
   output logic [7:0]          xfer_cnt,
   output logic                timeout
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t      state;
   logic [2:0]  last;
   logic [3:0]  gap_cnt;
   logic        found;
   logic [2:0]  win;
   logic        xfer;
   logic        abort;
   logic        end_send;

   // First requester after the last winner, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[(int'(last) + k) % NREQ]) begin
            found = 1'b1;
            win   = 3'((int'(last) + k) % NREQ);
         end
      end
   end

`ifdef NIB_RR_SCHED_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_r;

   assign timeout = timeout_r;
   assign abort   = (state == S_SEND) && !dp_ready &&
                    (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
   assign abort   = 1'b0;
`endif

   assign xfer     = (state == S_SEND) && dp_ready;
   assign end_send = xfer || abort;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         last     <= 3'(NREQ - 1);
         gap_cnt  <= 4'd0;
         grant    <= '0;
         dp_valid <= 1'b0;
         dp_data  <= '0;
         dp_src   <= 3'd0;
         busy     <= 1'b0;
         xfer_cnt <= 8'd0;
`ifdef NIB_RR_SCHED_TIMEOUT_EN
         wait_cnt  <= '0;
         timeout_r <= 1'b0;
`endif
      end else begin
`ifdef NIB_RR_SCHED_TIMEOUT_EN
         timeout_r <= abort;
`endif
         case (state)
            S_IDLE: begin
               if (found) begin
                  dp_data  <= data_in[int'(win)*W +: W];
                  dp_src   <= win;
                  grant    <= NREQ'(1) << win;
                  dp_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_SEND;
`ifdef NIB_RR_SCHED_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            S_SEND: begin
               if (end_send) begin
                  dp_valid <= 1'b0;
                  grant    <= '0;
                  last     <= dp_src;
                  if (GAP > 0) begin
                     state   <= S_GAP;
                     gap_cnt <= GAP_LOAD;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
`ifdef NIB_RR_SCHED_TIMEOUT_EN
               else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
               if (xfer)
                  xfer_cnt <= xfer_cnt + 8'd1;
            end
            S_GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nib_rr_sched.sv
// Directed bench for nib_rr_sched: one instance with GAP=2, one with GAP=0.
module tb_nib_rr_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [3:0]  a_req = '0;
   logic [15:0] a_data = '0;
   logic        a_ready = 1'b0;
   logic [3:0]  a_grant;
   logic        a_valid;
   logic [3:0]  a_dpdata;
   logic [2:0]  a_src;
   logic        a_busy;
   logic [7:0]  a_cnt;
   logic        a_to;

   logic [3:0]  b_req = '0;
   logic [15:0] b_data = '0;
   logic        b_ready = 1'b0;
   logic [3:0]  b_grant;
   logic        b_valid;
   logic [3:0]  b_dpdata;
   logic [2:0]  b_src;
   logic        b_busy;
   logic [7:0]  b_cnt;
   logic        b_to;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nib_rr_sched #(.NREQ(4), .W(4), .GAP(2), .TIMEOUT(15)) u_a (
      .clk(clk), .rst(rst), .req(a_req), .data_in(a_data), .grant(a_grant),
      .dp_valid(a_valid), .dp_ready(a_ready), .dp_data(a_dpdata), .dp_src(a_src),
      .busy(a_busy), .xfer_cnt(a_cnt), .timeout(a_to));

   nib_rr_sched #(.NREQ(4), .W(4), .GAP(0), .TIMEOUT(15)) u_b (
      .clk(clk), .rst(rst), .req(b_req), .data_in(b_data), .grant(b_grant),
      .dp_valid(b_valid), .dp_ready(b_ready), .dp_data(b_dpdata), .dp_src(b_src),
      .busy(b_busy), .xfer_cnt(b_cnt), .timeout(b_to));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      step();
      step();
      chk("rst_grant",  32'(a_grant), 0);
      chk("rst_valid",  32'(a_valid), 0);
      chk("rst_data",   32'(a_dpdata), 0);
      chk("rst_src",    32'(a_src), 0);
      chk("rst_busy",   32'(a_busy), 0);
      chk("rst_cnt",    32'(a_cnt), 0);
      chk("rst_to",     32'(a_to), 0);
      chk("rst_b_busy", 32'(b_busy), 0);
      rst = 1'b1;

      // single request, transfer on first valid cycle, then GAP spacing
      a_req = 4'b0001; a_data = 16'h000A; a_ready = 1'b1;
      step();
      chk("t1_grant", 32'(a_grant), 32'h1);
      chk("t1_valid", 32'(a_valid), 1);
      chk("t1_data",  32'(a_dpdata), 32'hA);
      chk("t1_src",   32'(a_src), 0);
      chk("t1_busy",  32'(a_busy), 1);
      step();
      chk("t1_xvalid", 32'(a_valid), 0);
      chk("t1_xgrant", 32'(a_grant), 0);
      chk("t1_cnt",    32'(a_cnt), 1);
      chk("t1_hold",   32'(a_dpdata), 32'hA);
      chk("t1_gbusy",  32'(a_busy), 1);
      step();
      chk("t1_gap1", 32'(a_grant), 0);
      step();
      chk("t1_gap2", 32'(a_grant), 0);
      chk("t1_idle", 32'(a_busy), 0);
      step();
      chk("t1_regrant", 32'(a_grant), 32'h1);
      a_req = 4'b0000;
      step();
      chk("t1_cnt2", 32'(a_cnt), 2);
      step();
      step();

      // all requesting: round-robin from reset pointer
      rst = 1'b0;
      step();
      rst = 1'b1;
      a_req = 4'b1111; a_data = 16'h4321; a_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t2_grant", 32'(a_grant), 32'(4'b0001 << (i % 4)));
         chk("t2_data",  32'(a_dpdata), 32'((i % 4) + 1));
         chk("t2_src",   32'(a_src), 32'(i % 4));
         step();
         chk("t2_valid", 32'(a_valid), 0);
         step();
         step();
      end
      chk("t2_cnt", 32'(a_cnt), 5);
      a_req = 4'b0000;
      step();

      // stall with dropped request
      a_req = 4'b0100; a_data = 16'h0700; a_ready = 1'b0;
      step();
      for (int i = 0; i < 7; i++) begin
         chk("t3_valid", 32'(a_valid), 1);
         chk("t3_data",  32'(a_dpdata), 32'h7);
         chk("t3_grant", 32'(a_grant), 32'h4);
         if (i == 1) a_req = 4'b0000;
         if (i == 6) a_ready = 1'b1;
         step();
      end
      chk("t3_xvalid", 32'(a_valid), 0);
      chk("t3_cnt",    32'(a_cnt), 6);
      chk("t3_src",    32'(a_src), 2);
      chk("t3_to",     32'(a_to), 0);
      step();
      step();

      // reset in the middle of SEND; pointer returns to requester 0 first
      a_req = 4'b0001; a_data = 16'h000B; a_ready = 1'b0;
      step();
      chk("t5_sending", 32'(a_valid), 1);
      step();
      rst = 1'b0;
      step();
      chk("t5_grant", 32'(a_grant), 0);
      chk("t5_valid", 32'(a_valid), 0);
      chk("t5_data",  32'(a_dpdata), 0);
      chk("t5_busy",  32'(a_busy), 0);
      chk("t5_cnt",   32'(a_cnt), 0);
      rst = 1'b1;
      a_req = 4'b1001; a_data = 16'hC00D;
      step();
      chk("t5_win",  32'(a_grant), 32'h1);
      chk("t5_wdat", 32'(a_dpdata), 32'hD);
      a_ready = 1'b1;
      a_req = 4'b1000;
      step();
      chk("t5_cnt1", 32'(a_cnt), 1);
      step();
      step();
      step();
      chk("t5_r3", 32'(a_grant), 32'h8);
      chk("t5_r3d", 32'(a_dpdata), 32'hC);
      a_req = 4'b0000;
      step();
      step();
      step();

      // long stall: abort when the timeout feature is built, else keep waiting
      rst = 1'b0;
      step();
      rst = 1'b1;
      a_req = 4'b0011; a_data = 16'h0021; a_ready = 1'b0;
      step();
      chk("t6_grant0", 32'(a_grant), 32'h1);
      for (int i = 1; i < 15; i++) begin
         step();
         chk("t6_wait", 32'(a_valid), 1);
         chk("t6_nto",  32'(a_to), 0);
      end
      step();
`ifdef NIB_RR_SCHED_TIMEOUT_EN
      chk("t6_to",    32'(a_to), 1);
      chk("t6_valid", 32'(a_valid), 0);
      chk("t6_cnt",   32'(a_cnt), 0);
      step();
      chk("t6_pulse", 32'(a_to), 0);
      step();
      step();
      chk("t6_next", 32'(a_grant), 32'h2);
`else
      chk("t6_to",    32'(a_to), 0);
      chk("t6_valid", 32'(a_valid), 1);
      a_ready = 1'b1;
      step();
      chk("t6_cnt", 32'(a_cnt), 1);
      step();
      step();
      step();
      chk("t6_next", 32'(a_grant), 32'h2);
`endif
      a_req = 4'b0000;

      // GAP=0: alternating grants, then wrap of the transfer counter
      b_req = 4'b0011; b_data = 16'h0021; b_ready = 1'b1;
      step();
      chk("t4_g0", 32'(b_grant), 32'h1);
      chk("t4_d0", 32'(b_dpdata), 32'h1);
      step();
      chk("t4_g1", 32'(b_grant), 0);
      chk("t4_c1", 32'(b_cnt), 1);
      step();
      chk("t4_g2", 32'(b_grant), 32'h2);
      chk("t4_d2", 32'(b_dpdata), 32'h2);
      step();
      chk("t4_g3", 32'(b_grant), 0);
      step();
      chk("t4_g4", 32'(b_grant), 32'h1);
      chk("t4_to", 32'(b_to), 0);
      for (int i = 0; i < 253; i++) begin
         step();
         step();
      end
      chk("t6_cnt255", 32'(b_cnt), 255);
      chk("t6_sendb",  32'(b_valid), 1);
      step();
      chk("t6_wrap", 32'(b_cnt), 0);
      b_req = 4'b0000;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nib_rr_sched.md
Name: nib_rr_sched

Overview:
- Round-robin scheduler sharing one 4-bit nibble datapath register stage among NREQ requesters.
- Each requester presents a nibble and a request.
- Scheduler picks a winner, latches its nibble, and drives the datapath through a valid/ready handshake.
- Enforces a programmable idle gap between transfers and keeps a running transfer count.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, nibble width.
- GAP, 2, idle cycles inserted after each completed transfer (0..15).
- TIMEOUT, 15, max cycles waiting for dp_ready; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- req  in  NREQ  per-requester request, level.
- data_in  in  NREQ*W  packed nibbles; requester i at [i*W +: W].
- grant  out  NREQ  one-hot grant to the current winner.
- dp_valid  out  1  datapath word valid.
- dp_ready  in  1  datapath accepts the word.
- dp_data  out  W  latched nibble of the winner.
- dp_src  out  3  index of the winner.
- busy  out  1  high in any state other than IDLE.
- xfer_cnt  out  8  completed transfers, wraps 255->0.
- timeout  out  1  one-cycle pulse on an aborted transfer.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs go to 0: grant, dp_valid, dp_data, dp_src, busy, xfer_cnt, timeout.
  - FSM goes to IDLE; round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Reset mid-transfer drops the transfer without counting it.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If any req bit is set, select the first set bit scanning last+1, last+2, ... modulo NREQ.
  - Register data_in of the winner into dp_data and its index into dp_src; set grant[winner] and dp_valid; go to SEND.
  - Latency: req sampled at edge N gives grant/dp_valid high after edge N.
  - With no req, stay in IDLE with all outputs static.
- SEND:
  - Hold dp_valid, dp_data, dp_src and grant stable until dp_ready=1 is sampled with dp_valid=1. That edge is the transfer.
  - On the transfer edge: clear dp_valid and grant, set last = dp_src, increment xfer_cnt (mod 256).
  - Next state is GAP if GAP>0, otherwise IDLE.
  - A winner that deasserts req during SEND does not cancel the transfer; the nibble is already latched.
  - Changes to data_in during SEND are ignored.
- GAP:
  - Internal counter loads GAP-1 on entry and decrements each cycle; at 0, go to IDLE.
  - req is ignored during GAP.
  - Transfer-to-next-grant spacing is GAP+1 edges.
- GAP=0 case: after the transfer edge the FSM is in IDLE, and a new grant appears one edge later. Back-to-back throughput is one word per 2 cycles minimum.
- Simultaneous requests: only the round-robin order decides the winner; there is no fixed priority beyond the reset pointer.
- Outputs dp_data and dp_src stay unchanged after a transfer until the next grant (not cleared).
- busy = (state != IDLE), registered along with the state.

Optional Feature:
- Macro: NIB_RR_SCHED_TIMEOUT_EN.
- Defined:
  - Wait counter clears on entry to SEND and increments each SEND cycle without dp_ready.
  - When it reaches TIMEOUT with dp_ready still 0: clear dp_valid and grant, pulse timeout for one cycle, set last = dp_src so the stuck requester loses priority, leave xfer_cnt unchanged, enter GAP (or IDLE if GAP=0).
  - dp_ready high on the same edge as the timeout wins: the transfer counts and there is no timeout.
- Undefined: SEND waits indefinitely; timeout is tied to 0; no wait counter is built.

Test Plan:
1. Reset, then req=4'b0001, data_in nibble0=4'hA, dp_ready=1 held → grant=0001, dp_valid=1, dp_data=A, dp_src=0 one edge after req; one-cycle valid; xfer_cnt=1; next grant no earlier than 3 edges after transfer (GAP=2).
2. req=4'b1111 held, nibbles 1,2,3,4, dp_ready=1 → grants in order 0,1,2,3,0; dp_data sequence 1,2,3,4,1; xfer_cnt=5.
3. Stall: req=4'b0100 (nibble=7), dp_ready=0 for 6 cycles then 1 → dp_valid/dp_data=7/grant=0100 stable for 7 cycles, single transfer, xfer_cnt+1. Dropping req on stall cycle 2 does not change the result.
4. GAP=0 with req=4'b0011 held → grant alternates 0001, 0000, 0010, 0000, 0001 each edge; throughput 1 word / 2 cycles.
5. rst=0 asserted mid-SEND with dp_ready=0 → next edge: all outputs 0, state IDLE, xfer_cnt=0; with req=4'b1000 after release, requester 3 wins on the first grant.
6. NIB_RR_SCHED_TIMEOUT_EN defined, TIMEOUT=15, req=4'b0011, dp_ready=0 → timeout pulses 15 cycles after grant, xfer_cnt unchanged, next grant goes to requester 1. With xfer_cnt preloaded via 255 transfers, one more transfer wraps it to 0.
